// File: rtl/mem_access_stage.sv
// Memory-access stage: forwards ALU results to write-back or runs one load/store
// over a ready/ack data-memory port, with store alignment and load extension.
module mem_access_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_ADDR_W = 9,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [DATA_WIDTH-1:0] ex_alu_result,
   input  logic [DATA_WIDTH-1:0] ex_rs2_data,
   input  logic [2:0]            ex_funct3,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic                  ex_reg_write,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  mem_fault
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                state, state_nxt;
   logic                  accept, is_mem, fault;
   logic [DATA_WIDTH-1:0] st_wdata, ld_data;
   logic [3:0]            st_be;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [2:0]            lat_f3;
   logic [REG_ADDR_W-1:0] lat_rd;
   logic                  lat_rw;

   assign accept = ex_valid && ex_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && is_mem && !fault) state_nxt = WAIT;
         WAIT:    if (mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ex_ready = (state == IDLE);
      mem_req  = (state == WAIT);
   end

   // Decode legality and build the aligned store word / byte enables.
   always_comb begin
      is_mem   = ex_mem_read | ex_mem_write;
      fault    = 1'b0;
      st_wdata = '0;
      st_be    = 4'b1111;
      if (ex_mem_read && ex_mem_write) begin
         fault = 1'b1;
      end else if (ex_mem_read) begin
         case (ex_funct3)
            3'b000, 3'b100: fault = 1'b0;
            3'b001, 3'b101: fault = ex_alu_result[0];
            3'b010:         fault = |ex_alu_result[1:0];
            default:        fault = 1'b1;
         endcase
      end else if (ex_mem_write) begin
         case (ex_funct3)
            3'b000: begin
               st_wdata = {4{ex_rs2_data[7:0]}};
               st_be    = 4'b0001 << ex_alu_result[1:0];
            end
            3'b001: begin
               st_wdata = {2{ex_rs2_data[15:0]}};
               st_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
               fault    = ex_alu_result[0];
            end
            3'b010: begin
               st_wdata = ex_rs2_data;
               fault    = |ex_alu_result[1:0];
            end
            default: fault = 1'b1;
         endcase
      end
   end

   always_comb begin
      case (mem_addr[1:0])
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lat_f3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_be       <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         mem_fault    <= 1'b0;
         lat_f3       <= '0;
         lat_rd       <= '0;
         lat_rw       <= 1'b0;
      end else begin
         wb_valid  <= 1'b0;
         mem_fault <= 1'b0;
         if (state == IDLE && accept) begin
            if (!is_mem) begin
               wb_valid     <= 1'b1;
               wb_data      <= ex_alu_result;
               wb_rd        <= ex_rd;
               wb_reg_write <= ex_reg_write && (ex_rd != '0);
            end else if (fault) begin
               wb_valid     <= 1'b1;
               mem_fault    <= 1'b1;
               wb_data      <= '0;
               wb_rd        <= ex_rd;
               wb_reg_write <= 1'b0;
            end else begin
               mem_we    <= ex_mem_write;
               mem_addr  <= ex_alu_result[MEM_ADDR_W-1:0];
               mem_wdata <= st_wdata;
               mem_be    <= st_be;
               lat_f3    <= ex_funct3;
               lat_rd    <= ex_rd;
               lat_rw    <= ex_reg_write;
            end
         end else if (state == WAIT && mem_ack) begin
            wb_valid     <= 1'b1;
            wb_rd        <= lat_rd;
            wb_data      <= mem_we ? '0 : ld_data;
            wb_reg_write <= !mem_we && lat_rw && (lat_rd != '0);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: pass-through, loads, stores,
// faults, stalling and reset during an outstanding request.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_alu_result, ex_rs2_data;
   logic [2:0]  ex_funct3;
   logic        ex_mem_read, ex_mem_write, ex_reg_write;
   logic [4:0]  ex_rd;
   logic        mem_req, mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid, wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_fault;

   int checks = 0;
   int fails  = 0;

   mem_access_stage #(.DATA_WIDTH(32), .MEM_ADDR_W(9), .REG_ADDR_W(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
      .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_valid = 0; ex_alu_result = '0; ex_rs2_data = '0; ex_funct3 = '0;
      ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_rd = '0;
      mem_ack = 0; mem_rdata = '0;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic rw, input logic [4:0] r);
      ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
      ex_alu_result = a; ex_rs2_data = d; ex_reg_write = rw; ex_rd = r;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 0;
      step(); step();
      checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
      checks++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL rst_wb_valid got %b exp 0", wb_valid); end
      checks++; if (wb_data !== 32'h0) begin fails++; $display("FAIL rst_wb_data got %h exp 0", wb_data); end
      checks++; if (mem_be !== 4'h0) begin fails++; $display("FAIL rst_mem_be got %b exp 0000", mem_be); end
      reset_n = 1;
      step();
      checks++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL rst_ex_ready got %b exp 1", ex_ready); end
   endtask

   task automatic test_non_mem();
      drive(0, 0, 3'b000, 32'h0000_0042, 32'h0, 1, 5'd5);
      step();
      checks++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL nm_wb_valid got %b exp 1", wb_valid); end
      checks++; if (wb_data !== 32'h42) begin fails++; $display("FAIL nm_wb_data got %h exp 00000042", wb_data); end
      checks++; if (wb_rd !== 5'd5) begin fails++; $display("FAIL nm_wb_rd got %0d exp 5", wb_rd); end
      checks++; if (wb_reg_write !== 1'b1) begin fails++; $display("FAIL nm_wb_reg_write got %b exp 1", wb_reg_write); end
      ex_rd = 5'd0;
      step();
      checks++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL nm_b2b_wb_valid got %b exp 1", wb_valid); end
      checks++; if (wb_reg_write !== 1'b0) begin fails++; $display("FAIL nm_rd0_reg_write got %b exp 0", wb_reg_write); end
      clear_inputs();
      step();
      checks++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL nm_idle_wb_valid got %b exp 0", wb_valid); end
      checks++; if (wb_data !== 32'h42) begin fails++; $display("FAIL nm_hold_wb_data got %h exp 00000042", wb_data); end
   endtask

   task automatic test_store_byte();
      drive(0, 1, 3'b000, 32'h0000_0013, 32'hAABB_CCDD, 1, 5'd7);
      step();
      clear_inputs();
      checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL sb_mem_req got %b exp 1", mem_req); end
      checks++; if (mem_we !== 1'b1) begin fails++; $display("FAIL sb_mem_we got %b exp 1", mem_we); end
      checks++; if (mem_be !== 4'b1000) begin fails++; $display("FAIL sb_mem_be got %b exp 1000", mem_be); end
      checks++; if (mem_wdata !== 32'hDDDD_DDDD) begin fails++; $display("FAIL sb_mem_wdata got %h exp dddddddd", mem_wdata); end
      checks++; if (mem_addr !== 9'h013) begin fails++; $display("FAIL sb_mem_addr got %h exp 013", mem_addr); end
      checks++; if (ex_ready !== 1'b0) begin fails++; $display("FAIL sb_ex_ready got %b exp 0", ex_ready); end
      step(); step();
      checks++; if (mem_req !== 1'b1 || mem_be !== 4'b1000) begin fails++; $display("FAIL sb_hold got req=%b be=%b exp req=1 be=1000", mem_req, mem_be); end
      mem_ack = 1;
      step();
      mem_ack = 0;
      checks++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL sb_wb_valid got %b exp 1", wb_valid); end
      checks++; if (wb_reg_write !== 1'b0) begin fails++; $display("FAIL sb_wb_reg_write got %b exp 0", wb_reg_write); end
      checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL sb_req_drop got %b exp 0", mem_req); end
      checks++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL sb_ready_back got %b exp 1", ex_ready); end
   endtask

   task automatic test_store_half();
      drive(0, 1, 3'b001, 32'h0000_0022, 32'h1234_5678, 0, 5'd0);
      step();
      clear_inputs();
      checks++; if (mem_be !== 4'b1100) begin fails++; $display("FAIL sh_mem_be got %b exp 1100", mem_be); end
      checks++; if (mem_wdata !== 32'h5678_5678) begin fails++; $display("FAIL sh_mem_wdata got %h exp 56785678", mem_wdata); end
      mem_ack = 1;
      step();
      mem_ack = 0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0) begin fails++; $display("FAIL sh_wb got valid=%b data=%h exp valid=1 data=0", wb_valid, wb_data); end
   endtask

   task automatic test_loads();
      drive(1, 0, 3'b000, 32'h0000_0002, 32'h0, 1, 5'd3);
      step();
      ex_valid = 0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111) begin fails++; $display("FAIL lb_req got req=%b we=%b be=%b exp 1 0 1111", mem_req, mem_we, mem_be); end
      checks++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL lb_wdata got %h exp 0", mem_wdata); end
      mem_ack = 1; mem_rdata = 32'h0080_0000;
      step();
      mem_ack = 0;
      checks++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL lb_wb_valid got %b exp 1", wb_valid); end
      checks++; if (wb_data !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_wb_data got %h exp ffffff80", wb_data); end
      checks++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd3) begin fails++; $display("FAIL lb_wb_rd got we=%b rd=%0d exp 1 3", wb_reg_write, wb_rd); end
      drive(1, 0, 3'b100, 32'h0000_0002, 32'h0, 1, 5'd4);
      step();
      ex_valid = 0;
      mem_ack = 1;
      step();
      mem_ack = 0;
      checks++; if (wb_data !== 32'h0000_0080) begin fails++; $display("FAIL lbu_wb_data got %h exp 00000080", wb_data); end
      drive(1, 0, 3'b001, 32'h0000_0002, 32'h0, 1, 5'd4);
      step();
      ex_valid = 0;
      mem_ack = 1; mem_rdata = 32'h8001_1234;
      step();
      mem_ack = 0;
      checks++; if (wb_data !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_wb_data got %h exp ffff8001", wb_data); end
      drive(1, 0, 3'b101, 32'h0000_0000, 32'h0, 1, 5'd4);
      step();
      ex_valid = 0;
      mem_ack = 1;
      step();
      clear_inputs();
      checks++; if (wb_data !== 32'h0000_1234) begin fails++; $display("FAIL lhu_wb_data got %h exp 00001234", wb_data); end
   endtask

   task automatic test_faults();
      drive(1, 0, 3'b010, 32'h0000_0006, 32'h0, 1, 5'd8);
      step();
      checks++; if (wb_valid !== 1'b1 || mem_fault !== 1'b1) begin fails++; $display("FAIL lw_mis got valid=%b fault=%b exp 1 1", wb_valid, mem_fault); end
      checks++; if (wb_reg_write !== 1'b0 || wb_data !== 32'h0) begin fails++; $display("FAIL lw_mis_wb got we=%b data=%h exp 0 0", wb_reg_write, wb_data); end
      checks++; if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin fails++; $display("FAIL lw_mis_req got req=%b ready=%b exp 0 1", mem_req, ex_ready); end
      drive(1, 1, 3'b010, 32'h0000_0000, 32'h0, 1, 5'd8);
      step();
      checks++; if (mem_fault !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL rdwr got fault=%b req=%b exp 1 0", mem_fault, mem_req); end
      drive(0, 1, 3'b011, 32'h0000_0000, 32'h0, 0, 5'd0);
      step();
      clear_inputs();
      checks++; if (mem_fault !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL bad_f3 got fault=%b req=%b exp 1 0", mem_fault, mem_req); end
      step();
      checks++; if (mem_fault !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("FAIL fault_pulse got fault=%b valid=%b exp 0 0", mem_fault, wb_valid); end
   endtask

   task automatic test_stall();
      drive(1, 0, 3'b010, 32'h0000_0004, 32'h0, 1, 5'd6);
      step();
      drive(0, 0, 3'b000, 32'h0000_0099, 32'h0, 1, 5'd9);
      checks++; if (ex_ready !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("FAIL stall_c1 got ready=%b req=%b exp 0 1", ex_ready, mem_req); end
      step();
      checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b0) begin fails++; $display("FAIL stall_c2 got valid=%b ready=%b exp 0 0", wb_valid, ex_ready); end
      mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE_F00D || wb_rd !== 5'd6) begin fails++; $display("FAIL stall_lw got valid=%b data=%h rd=%0d exp 1 cafef00d 6", wb_valid, wb_data, wb_rd); end
      checks++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL stall_ready got %b exp 1", ex_ready); end
      step();
      clear_inputs();
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h99 || wb_rd !== 5'd9) begin fails++; $display("FAIL stall_next got valid=%b data=%h rd=%0d exp 1 00000099 9", wb_valid, wb_data, wb_rd); end
      step();
      mem_ack = 1;
      step();
      mem_ack = 0;
      checks++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL spurious_ack got valid=%b req=%b exp 0 0", wb_valid, mem_req); end
   endtask

   task automatic test_reset_in_wait();
      drive(1, 0, 3'b010, 32'h0000_0008, 32'h0, 1, 5'd2);
      step();
      clear_inputs();
      checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rw_req got %b exp 1", mem_req); end
      reset_n = 0;
      #1;
      checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rw_async_drop got %b exp 0", mem_req); end
      step();
      reset_n = 1;
      step();
      checks++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL rw_ready got %b exp 1", ex_ready); end
      mem_ack = 1;
      step();
      mem_ack = 0;
      checks++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL rw_late_ack got valid=%b req=%b exp 0 0", wb_valid, mem_req); end
   endtask

   initial begin
      test_reset();
      test_non_mem();
      test_store_byte();
      test_store_half();
      test_loads();
      test_faults();
      test_stall();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
